// File: rtl/mem_access_stage.sv
// rtl/mem_access_stage.sv - MEM-stage load/store unit with a ready-handshake data port and a timeout
// Formats loads, lane-replicates stores and stalls the pipeline while a data-memory access is outstanding.
module mem_access_stage #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemReadM,
  input  logic        MemWriteM,
  input  logic [2:0]  Funct3M,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  output logic [31:0] ReadDataM,
  output logic        StallM,
  output logic        MisalignM,
  output logic        BusErrM,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ready
);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT_CYCLES);

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic             acc, is_byte, is_half, is_word;
  logic             misalign_raw, va;
  logic             req, stall, timeout_hit;
  logic [1:0]       lane;
  logic [7:0]       load_byte;
  logic [15:0]      load_half;
  logic [31:0]      load_fmt;

  assign acc     = MemReadM | MemWriteM;
  assign lane    = ALUResultM[1:0];
  assign is_byte = (Funct3M[1:0] == 2'b00);
  assign is_half = (Funct3M[1:0] == 2'b01);
  // Reserved encodings fall into the word class.
  assign is_word = ~is_byte & ~is_half;

  assign misalign_raw = acc & ((is_word & (lane != 2'b00)) | (is_half & lane[0]));
  assign va           = acc & ~misalign_raw;
  assign MisalignM    = reset & (state == IDLE) & misalign_raw;

  assign dmem_addr = {ALUResultM[31:2], 2'b00};
  assign dmem_we   = MemWriteM;

  always_comb begin
    dmem_be    = 4'b1111;
    dmem_wdata = WriteDataM;
    if (is_byte) begin
      dmem_be    = 4'b0001 << lane;
      dmem_wdata = {4{WriteDataM[7:0]}};
    end else if (is_half) begin
      dmem_be    = 4'b0011 << {lane[1], 1'b0};
      dmem_wdata = {2{WriteDataM[15:0]}};
    end
  end

  always_comb begin
    load_byte = dmem_rdata[{lane, 3'b000} +: 8];
    load_half = lane[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    if (is_byte)
      load_fmt = {{24{~Funct3M[2] & load_byte[7]}}, load_byte};
    else if (is_half)
      load_fmt = {{16{~Funct3M[2] & load_half[15]}}, load_half};
    else
      load_fmt = dmem_rdata;
  end

  always_comb begin
    state_next  = state;
    cnt_next    = cnt;
    req         = 1'b0;
    stall       = 1'b0;
    timeout_hit = 1'b0;
    case (state)
      IDLE: begin
        req   = va;
        stall = va;
        if (va && dmem_ready) begin
          state_next = DONE;
        end else if (va) begin
          state_next = WAIT;
          cnt_next   = CNT_W'(1);
        end
      end
      WAIT: begin
        req   = 1'b1;
        stall = 1'b1;
        // A ready arriving on the last allowed cycle still completes normally.
        if (dmem_ready) begin
          state_next = DONE;
        end else if (cnt == TIMEOUT_CNT) begin
          state_next  = DONE;
          timeout_hit = 1'b1;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      DONE: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  assign dmem_req = reset & req;
  assign StallM   = reset & stall;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= '0;
      ReadDataM <= '0;
      BusErrM   <= 1'b0;
    end else begin
      state   <= state_next;
      cnt     <= cnt_next;
      BusErrM <= timeout_hit;
      if (timeout_hit)
        ReadDataM <= '0;
      else if ((state != DONE) && (state_next == DONE) && !MemWriteM)
        ReadDataM <= load_fmt;
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// tb/tb_mem_access_stage.sv - self-checking bench for mem_access_stage with a behavioural reference model
// Directed scenarios plus randomized accesses; all expectations come from the model functions below.
module tb_mem_access_stage;

  localparam int TO = 4;

  logic        clk;
  logic        reset;
  logic        MemReadM, MemWriteM;
  logic [2:0]  Funct3M;
  logic [31:0] ALUResultM, WriteDataM;
  logic [31:0] ReadDataM;
  logic        StallM, MisalignM, BusErrM;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata, dmem_rdata;
  logic        dmem_ready;

  int          total = 0;
  int          bad   = 0;
  logic [31:0] exp_rd;

  mem_access_stage #(.TIMEOUT_CYCLES(TO), .CNT_W(3)) dut (
    .clk(clk), .reset(reset),
    .MemReadM(MemReadM), .MemWriteM(MemWriteM), .Funct3M(Funct3M),
    .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
    .ReadDataM(ReadDataM), .StallM(StallM), .MisalignM(MisalignM), .BusErrM(BusErrM),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
    .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ready(dmem_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int nbytes(input logic [2:0] f);
    case (f)
      3'd0, 3'd4: return 1;
      3'd1, 3'd5: return 2;
      default:    return 4;
    endcase
  endfunction

  function automatic int m_off(input logic [2:0] f, input logic [31:0] a);
    int n;
    n = nbytes(f);
    return (n == 4) ? 0 : (int'(a % 4) / n) * n;
  endfunction

  function automatic logic [3:0] m_be(input logic [2:0] f, input logic [31:0] a);
    int n;
    n = nbytes(f);
    return 4'(((1 << n) - 1) << m_off(f, a));
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f, input logic [31:0] wd);
    logic [31:0] r;
    int n;
    n = nbytes(f);
    for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % n) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f, input logic [31:0] a, input logic [31:0] rdv);
    logic [31:0] v, keep;
    int n;
    n = nbytes(f);
    v = rdv >> (8 * m_off(f, a));
    if (n < 4) begin
      keep = (32'd1 << (8 * n)) - 32'd1;
      v = v & keep;
      if (!f[2] && v[8*n-1]) v = v | ~keep;
    end
    return v;
  endfunction

  // One complete access: wt = WAIT index at which ready arrives; wt > TO means never.
  task automatic do_access(input bit wr, input bit rd, input logic [2:0] f, input logic [31:0] a,
                           input logic [31:0] wd, input int wt, input logic [31:0] rdv, input bit gap);
    int k;
    bit to;
    int exp_stall;
    to = (wt > TO);
    exp_stall = to ? TO + 1 : wt + 1;
    MemWriteM = wr; MemReadM = rd; Funct3M = f; ALUResultM = a; WriteDataM = wd;
    k = 0;
    while (1) begin
      dmem_ready = (k == wt) && !to;
      dmem_rdata = dmem_ready ? rdv : $urandom;
      @(negedge clk);
      if (!StallM) break;
      total++;
      if (dmem_req !== 1'b1 || dmem_we !== wr || dmem_addr !== {a[31:2], 2'b00} ||
          dmem_be !== m_be(f, a) || dmem_wdata !== m_wdata(f, wd) || MisalignM !== 1'b0) begin
        bad++;
        $display("FAIL req_cycle k=%0d got req=%b we=%b addr=%h be=%b wdata=%h mis=%b want we=%b addr=%h be=%b wdata=%h",
                 k, dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata, MisalignM,
                 wr, {a[31:2], 2'b00}, m_be(f, a), m_wdata(f, wd));
      end
      k++;
      if (k > 20) begin
        bad++;
        $display("FAIL stall_bound got stall still high after %0d cycles want %0d", k, exp_stall);
        break;
      end
      @(posedge clk); #1;
    end
    total++;
    if (k !== exp_stall) begin
      bad++;
      $display("FAIL stall_cycles f=%0d addr=%h got %0d want %0d", f, a, k, exp_stall);
    end
    if (to) exp_rd = '0;
    else if (rd && !wr) exp_rd = m_load(f, a, rdv);
    total++;
    if (ReadDataM !== exp_rd || BusErrM !== to || dmem_req !== 1'b0) begin
      bad++;
      $display("FAIL done_cycle f=%0d addr=%h got rdata=%h buserr=%b req=%b want rdata=%h buserr=%b req=0",
               f, a, ReadDataM, BusErrM, dmem_req, exp_rd, to);
    end
    @(posedge clk); #1;
    if (gap) begin
      MemReadM = 1'b0; MemWriteM = 1'b0;
      dmem_ready = 1'($urandom);
      @(negedge clk);
      total++;
      if (BusErrM !== 1'b0 || StallM !== 1'b0 || dmem_req !== 1'b0 || ReadDataM !== exp_rd) begin
        bad++;
        $display("FAIL idle_after got buserr=%b stall=%b req=%b rdata=%h want 0 0 0 %h",
                 BusErrM, StallM, dmem_req, ReadDataM, exp_rd);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; dmem_ready = 1'b1; dmem_rdata = 32'h1234_5678;
    MemReadM = 1'b1; MemWriteM = 1'b0; Funct3M = 3'd2; WriteDataM = '0;
    ALUResultM = 32'h101;
    @(negedge clk);
    total++;
    if (ReadDataM !== 32'h0 || BusErrM !== 1'b0 || dmem_req !== 1'b0 || StallM !== 1'b0 || MisalignM !== 1'b0) begin
      bad++;
      $display("FAIL reset_misaligned got rdata=%h buserr=%b req=%b stall=%b mis=%b want all 0",
               ReadDataM, BusErrM, dmem_req, StallM, MisalignM);
    end
    ALUResultM = 32'h100;
    @(negedge clk);
    total++;
    if (ReadDataM !== 32'h0 || dmem_req !== 1'b0 || StallM !== 1'b0) begin
      bad++;
      $display("FAIL reset_valid got rdata=%h req=%b stall=%b want 0 0 0", ReadDataM, dmem_req, StallM);
    end
    MemReadM = 1'b0; dmem_ready = 1'b0;
    reset = 1'b1;
    exp_rd = '0;
    @(posedge clk); #1;
  endtask

  task automatic test_plan();
    do_access(1'b0, 1'b1, 3'd2, 32'h100, 32'h0, 3, 32'hDEADBEEF, 1'b1);
    total++;
    if (ReadDataM !== 32'hDEADBEEF) begin bad++; $display("FAIL lw_value got %h want deadbeef", ReadDataM); end
    do_access(1'b0, 1'b1, 3'd0, 32'h203, 32'h0, 0, 32'h80FF1234, 1'b1);
    total++;
    if (ReadDataM !== 32'hFFFFFF80) begin bad++; $display("FAIL lb_value got %h want ffffff80", ReadDataM); end
    do_access(1'b0, 1'b1, 3'd4, 32'h203, 32'h0, 0, 32'h80FF1234, 1'b1);
    total++;
    if (ReadDataM !== 32'h00000080) begin bad++; $display("FAIL lbu_value got %h want 00000080", ReadDataM); end
    do_access(1'b1, 1'b0, 3'd1, 32'h302, 32'h0000ABCD, 1, 32'h5555AAAA, 1'b1);
    total++;
    if (ReadDataM !== 32'h00000080) begin bad++; $display("FAIL sh_hold got %h want 00000080", ReadDataM); end
  endtask

  task automatic test_misalign();
    logic [2:0]  fs[4] = '{3'd2, 3'd1, 3'd5, 3'd2};
    logic [31:0] as[4] = '{32'h101, 32'h203, 32'h1FF, 32'h302};
    bit          ws[4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 4; i++) begin
      MemWriteM = ws[i]; MemReadM = ~ws[i]; Funct3M = fs[i]; ALUResultM = as[i];
      WriteDataM = $urandom;
      for (int c = 0; c < 2; c++) begin
        dmem_ready = 1'($urandom); dmem_rdata = $urandom;
        @(negedge clk);
        total++;
        if (MisalignM !== 1'b1 || dmem_req !== 1'b0 || StallM !== 1'b0 || ReadDataM !== exp_rd || BusErrM !== 1'b0) begin
          bad++;
          $display("FAIL misalign_%0d got mis=%b req=%b stall=%b rdata=%h buserr=%b want 1 0 0 %h 0",
                   i, MisalignM, dmem_req, StallM, ReadDataM, BusErrM, exp_rd);
        end
        @(posedge clk); #1;
      end
    end
    MemWriteM = 1'b0; MemReadM = 1'b0; ALUResultM = 32'h103;
    @(negedge clk);
    total++;
    if (MisalignM !== 1'b0) begin bad++; $display("FAIL misalign_noacc got %b want 0", MisalignM); end
    @(posedge clk); #1;
    do_access(1'b0, 1'b1, 3'd2, 32'h104, 32'h0, 0, 32'hCAFEF00D, 1'b1);
  endtask

  task automatic test_timeout();
    do_access(1'b0, 1'b1, 3'd2, 32'h400, 32'h0, 99, 32'h0, 1'b1);
    total++;
    if (ReadDataM !== 32'h0) begin bad++; $display("FAIL timeout_clear got %h want 0", ReadDataM); end
    do_access(1'b0, 1'b1, 3'd2, 32'h404, 32'h0, TO, 32'h0BADF00D, 1'b1);
    do_access(1'b1, 1'b0, 3'd0, 32'h405, 32'h77, 99, 32'h0, 1'b1);
  endtask

  task automatic test_reset_mid();
    do_access(1'b0, 1'b1, 3'd2, 32'h500, 32'h0, 0, 32'h12345678, 1'b1);
    MemReadM = 1'b1; MemWriteM = 1'b0; Funct3M = 3'd2; ALUResultM = 32'h504;
    dmem_ready = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #2;
    reset = 1'b0;
    #1;
    total++;
    if (dmem_req !== 1'b0 || StallM !== 1'b0 || ReadDataM !== 32'h0) begin
      bad++;
      $display("FAIL reset_mid got req=%b stall=%b rdata=%h want 0 0 0", dmem_req, StallM, ReadDataM);
    end
    MemReadM = 1'b0;
    dmem_ready = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    dmem_ready = 1'b0;
    exp_rd = '0;
    @(posedge clk); #1;
    @(negedge clk);
    total++;
    if (StallM !== 1'b0 || dmem_req !== 1'b0 || BusErrM !== 1'b0 || ReadDataM !== 32'h0) begin
      bad++;
      $display("FAIL after_reset got stall=%b req=%b buserr=%b rdata=%h want 0 0 0 0",
               StallM, dmem_req, BusErrM, ReadDataM);
    end
    @(posedge clk); #1;
    do_access(1'b0, 1'b1, 3'd2, 32'h504, 32'h0, 2, 32'hA5A5_5A5A, 1'b1);
  endtask

  task automatic test_back_to_back();
    do_access(1'b0, 1'b1, 3'd1, 32'h602, 32'h0, 0, 32'h8001_7FFF, 1'b0);
    do_access(1'b1, 1'b1, 3'd2, 32'h604, 32'h1122_3344, 1, 32'hFFFF_FFFF, 1'b0);
    do_access(1'b0, 1'b1, 3'd5, 32'h606, 32'h0, 2, 32'h8001_7FFF, 1'b1);
  endtask

  task automatic test_random();
    logic [2:0]  f;
    logic [31:0] a;
    bit          wr, rd;
    for (int i = 0; i < 40; i++) begin
      f  = 3'($urandom_range(0, 7));
      wr = 1'($urandom_range(0, 1));
      rd = wr ? 1'($urandom_range(0, 1)) : 1'b1;
      a  = $urandom & ~32'(nbytes(f) - 1);
      do_access(wr, rd, f, a, $urandom, $urandom_range(0, 6), $urandom, 1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    MemReadM = 1'b0; MemWriteM = 1'b0; Funct3M = '0; ALUResultM = '0; WriteDataM = '0;
    dmem_rdata = '0; dmem_ready = 1'b0; reset = 1'b0; exp_rd = '0;
    test_reset();
    test_plan();
    test_misalign();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
